// File: rtl/fp_mul_arbiter.sv
// Round-robin arbiter sharing one combinational FP multiplier between two requesters.
// Operands are held for LAT cycles, then the result is returned on a tagged response channel.
module fp_mul_arbiter #(
  parameter int LAT = 2,
  parameter int CW  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_x,
  input  logic [31:0] req0_y,
  input  logic [2:0]  req0_rmode,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_x,
  input  logic [31:0] req1_y,
  input  logic [2:0]  req1_rmode,
  output logic [31:0] mul_x,
  output logic [31:0] mul_y,
  output logic [2:0]  mul_rmode,
  input  logic [31:0] mul_z,
  input  logic        mul_ovrf,
  input  logic        mul_udrf,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_z,
  output logic        rsp_ovrf,
  output logic        rsp_udrf,
  output logic        rsp_badrm,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state, state_nxt;
  logic            ptr;
  logic [CW-1:0]   cnt;
  logic            id_q;
  logic            badrm_q;
  logic            grant_any;
  logic            grant_id;
  logic            accept;
  logic [2:0]      sel_rmode;

  // Pointer only breaks ties; a lone requester always wins.
  always_comb begin
    grant_any = req0_valid | req1_valid;
    grant_id  = (req0_valid & req1_valid) ? ptr : req1_valid;
    sel_rmode = grant_id ? req1_rmode : req0_rmode;
  end

  // Ready is gated by rst_n so that all outputs read 0 while reset is held.
  assign req0_ready = rst_n & (state == IDLE) & grant_any & ~grant_id;
  assign req1_ready = rst_n & (state == IDLE) & grant_any &  grant_id;
  assign accept     = req0_ready | req1_ready;
  assign rsp_valid  = (state == DONE);
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = BUSY;
      BUSY:    if (cnt == '0) state_nxt = DONE;
      DONE:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand latch, settle counter and result capture; mul_* change only on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_x     <= '0;
      mul_y     <= '0;
      mul_rmode <= '0;
      ptr       <= 1'b0;
      cnt       <= '0;
      id_q      <= 1'b0;
      badrm_q   <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_z     <= '0;
      rsp_ovrf  <= 1'b0;
      rsp_udrf  <= 1'b0;
      rsp_badrm <= 1'b0;
    end else begin
      if (accept) begin
        mul_x     <= grant_id ? req1_x : req0_x;
        mul_y     <= grant_id ? req1_y : req0_y;
        mul_rmode <= (sel_rmode > 3'd4) ? 3'd0 : sel_rmode;
        badrm_q   <= (sel_rmode > 3'd4);
        id_q      <= grant_id;
        cnt       <= CW'(LAT - 1);
        ptr       <= ~grant_id;
      end else if (state == BUSY) begin
        if (cnt == '0) begin
          rsp_id    <= id_q;
          rsp_z     <= mul_z;
          rsp_ovrf  <= mul_ovrf;
          rsp_udrf  <= mul_udrf;
          rsp_badrm <= badrm_q;
        end else begin
          cnt <= cnt - CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Self-checking bench for fp_mul_arbiter: stub multiplier that only settles after LAT
// stable cycles, plus a transaction-level reference model checked every cycle.
module tb_fp_mul_arbiter;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid, rsp_ready;
  logic [31:0] req0_x, req0_y, req1_x, req1_y;
  logic [2:0]  req0_rmode, req1_rmode;
  logic        req0_ready, req1_ready;
  logic [31:0] mul_x, mul_y, mul_z, rsp_z;
  logic [2:0]  mul_rmode;
  logic        mul_ovrf, mul_udrf;
  logic        rsp_valid, rsp_id, rsp_ovrf, rsp_udrf, rsp_badrm, busy;

  int total = 0;
  int bad   = 0;

  fp_mul_arbiter #(.LAT(LAT), .CW(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_x(req0_x), .req0_y(req0_y), .req0_rmode(req0_rmode),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_x(req1_x), .req1_y(req1_y), .req1_rmode(req1_rmode),
    .mul_x(mul_x), .mul_y(mul_y), .mul_rmode(mul_rmode),
    .mul_z(mul_z), .mul_ovrf(mul_ovrf), .mul_udrf(mul_udrf),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_z(rsp_z),
    .rsp_ovrf(rsp_ovrf), .rsp_udrf(rsp_udrf), .rsp_badrm(rsp_badrm), .busy(busy)
  );

  always #5 clk = ~clk;

  // Stand-in multiplier: real products for the directed cases, a deterministic mix otherwise.
  function automatic logic [31:0] fmul(input logic [31:0] x, input logic [31:0] y, input logic [2:0] rm);
    if (x == 32'h40400000 && y == 32'h40400000) return 32'h41100000;
    if (x[30:0] == 31'd0 || y[30:0] == 31'd0) return {x[31] ^ y[31], 31'd0};
    return (x ^ {y[15:0], y[31:16]}) + {29'd0, rm};
  endfunction

  function automatic logic fovf(input logic [31:0] x);
    return ^x[7:0];
  endfunction

  // Output reads as inverted garbage until operands have been stable for LAT cycles.
  logic [4:0]  stable = 5'd0;
  logic [66:0] prev   = '1;
  always @(negedge clk) begin
    if ({mul_x, mul_y, mul_rmode} !== prev) stable <= 5'd1;
    else if (stable != 5'd31) stable <= stable + 5'd1;
    prev <= {mul_x, mul_y, mul_rmode};
  end

  always_comb begin
    mul_z    = fmul(mul_x, mul_y, mul_rmode);
    mul_ovrf = fovf(mul_x);
    mul_udrf = fovf(mul_y);
    if (int'(stable) < LAT) begin
      mul_z    = ~mul_z;
      mul_ovrf = ~mul_ovrf;
      mul_udrf = ~mul_udrf;
    end
  end

  // Reference model state
  int          cyc = 0;
  bit          outstanding = 0;
  int          acc_cyc = 0;
  int          hs_cyc = 0;
  bit          ptr_m = 0;
  bit          acc_now = 0;
  logic [31:0] ex_x = 0, ex_y = 0, ex_z = 0;
  logic [2:0]  ex_rm = 0;
  logic        ex_id = 0, ex_bad = 0, ex_ov = 0, ex_ud = 0;
  int          acc_cyc_q[$];
  int          acc_id_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: got %h want %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic checkOutput();
    bit exp_valid, g, r0, r1;
    logic [2:0] rm;
    acc_now = 0;
    if (!rst_n) begin
      outstanding = 0; ptr_m = 0;
      ex_x = 0; ex_y = 0; ex_rm = 0;
      chk("rst_ready0", 32'(req0_ready), 0);
      chk("rst_ready1", 32'(req1_ready), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_rsp_valid", 32'(rsp_valid), 0);
      chk("rst_mul_x", mul_x, 0);
      chk("rst_mul_y", mul_y, 0);
      chk("rst_mul_rmode", 32'(mul_rmode), 0);
      chk("rst_rsp", {rsp_z[28:0], rsp_id, rsp_ovrf, rsp_udrf | rsp_badrm}, 0);
      cyc++;
      return;
    end
    exp_valid = outstanding && (cyc >= acc_cyc + LAT + 1);
    g  = (req0_valid && req1_valid) ? ptr_m : req1_valid;
    r0 = !outstanding && (req0_valid || req1_valid) && !g;
    r1 = !outstanding && (req0_valid || req1_valid) && g;
    chk("ready0", 32'(req0_ready), 32'(r0));
    chk("ready1", 32'(req1_ready), 32'(r1));
    chk("busy", 32'(busy), 32'(outstanding));
    chk("rsp_valid", 32'(rsp_valid), 32'(exp_valid));
    chk("mul_x", mul_x, ex_x);
    chk("mul_y", mul_y, ex_y);
    chk("mul_rmode", 32'(mul_rmode), 32'(ex_rm));
    if (exp_valid) begin
      chk("rsp_id", 32'(rsp_id), 32'(ex_id));
      chk("rsp_z", rsp_z, ex_z);
      chk("rsp_ovrf", 32'(rsp_ovrf), 32'(ex_ov));
      chk("rsp_udrf", 32'(rsp_udrf), 32'(ex_ud));
      chk("rsp_badrm", 32'(rsp_badrm), 32'(ex_bad));
    end
    if (exp_valid && rsp_ready) begin
      outstanding = 0;
      hs_cyc = cyc;
    end else if (r0 || r1) begin
      ex_id  = r1;
      ex_x   = r1 ? req1_x : req0_x;
      ex_y   = r1 ? req1_y : req0_y;
      rm     = r1 ? req1_rmode : req0_rmode;
      ex_bad = (rm > 3'd4);
      ex_rm  = ex_bad ? 3'd0 : rm;
      ex_z   = fmul(ex_x, ex_y, ex_rm);
      ex_ov  = fovf(ex_x);
      ex_ud  = fovf(ex_y);
      ptr_m  = !r1;
      outstanding = 1;
      acc_cyc = cyc;
      acc_now = 1;
      acc_cyc_q.push_back(cyc);
      acc_id_q.push_back(int'(r1));
    end
    cyc++;
  endtask

  task automatic step();
    @(negedge clk);
    checkOutput();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input bit id, input logic v, input logic [31:0] x,
                               input logic [31:0] y, input logic [2:0] rm);
    if (id) begin
      req1_valid = v; req1_x = x; req1_y = y; req1_rmode = rm;
    end else begin
      req0_valid = v; req0_x = x; req0_y = y; req0_rmode = rm;
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_n = 1'b0;
    rsp_ready = 1'b1;
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    repeat (2) step();
    rst_n = 1'b1;
    step();

    // Single requester 0: 3.0 * 3.0, RTZ
    applyStimulus(0, 1, 32'h40400000, 32'h40400000, 3'b001);
    step();
    chk("t1_accept", 32'(acc_now), 1);
    applyStimulus(0, 0, 0, 0, 0);
    repeat (LAT + 3) step();

    // Requester 1 with illegal rmode: executed as RNE, flagged badrm
    applyStimulus(1, 1, 32'h00000000, 32'h40490fdb, 3'b110);
    step();
    chk("t4_accept", 32'(acc_now), 1);
    applyStimulus(1, 0, 0, 0, 0);
    repeat (LAT + 3) step();
    chk("t4_rsp_z_last", rsp_z, 32'h00000000);
    chk("t4_badrm_last", 32'(rsp_badrm), 1);

    // Both requesters contend for three operations
    acc_cyc_q.delete();
    acc_id_q.delete();
    applyStimulus(0, 1, $urandom, $urandom, 3'($urandom_range(0, 4)));
    applyStimulus(1, 1, $urandom, $urandom, 3'($urandom_range(0, 4)));
    for (int i = 0; i < 20; i++) begin
      step();
      if (acc_now) begin
        if (acc_id_q.size() >= 3) begin
          applyStimulus(0, 0, 0, 0, 0);
          applyStimulus(1, 0, 0, 0, 0);
        end else begin
          applyStimulus(ex_id, 1, $urandom, $urandom, 3'($urandom_range(0, 4)));
        end
      end
    end
    chk("t2_count", 32'(acc_id_q.size()), 3);
    if (acc_id_q.size() == 3) begin
      chk("t2_order0", 32'(acc_id_q[0]), 0);
      chk("t2_order1", 32'(acc_id_q[1]), 1);
      chk("t2_order2", 32'(acc_id_q[2]), 0);
      chk("t2_gap01", 32'(acc_cyc_q[1] - acc_cyc_q[0]), 32'(LAT + 2));
      chk("t2_gap12", 32'(acc_cyc_q[2] - acc_cyc_q[1]), 32'(LAT + 2));
    end

    // Backpressure on the response while requester 1 waits
    applyStimulus(0, 1, $urandom, $urandom, 3'd2);
    step();
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(1, 1, $urandom, $urandom, 3'd3);
    rsp_ready = 1'b0;
    repeat (LAT + 6) step();
    chk("t3_held_valid", 32'(rsp_valid), 1);
    rsp_ready = 1'b1;
    step();
    step();
    chk("t3_accept_r1", 32'(acc_now), 1);
    chk("t3_bubble", 32'(acc_cyc - hs_cyc), 1);
    applyStimulus(1, 0, 0, 0, 0);
    repeat (LAT + 3) step();

    // Reset pulse while BUSY discards the operation and restores the pointer
    applyStimulus(0, 1, 32'h3f800000, 32'h40000000, 3'd0);
    step();
    applyStimulus(0, 0, 0, 0, 0);
    step();
    applyStimulus(0, 1, $urandom, $urandom, 3'd1);
    applyStimulus(1, 1, $urandom, $urandom, 3'd1);
    rst_n = 1'b0;
    #1;
    chk("async_busy", 32'(busy), 0);
    chk("async_mul_x", mul_x, 0);
    chk("async_ready", 32'({req0_ready, req1_ready}), 0);
    repeat (2) step();
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    rst_n = 1'b1;
    repeat (LAT + 3) step();
    applyStimulus(0, 1, $urandom, $urandom, 3'd4);
    applyStimulus(1, 1, $urandom, $urandom, 3'd4);
    step();
    chk("rst_grant_r0", 32'(acc_id_q[$]), 0);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    repeat (LAT + 3) step();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      applyStimulus(0, 1'($urandom_range(0, 2) != 0), $urandom, $urandom, 3'($urandom_range(0, 7)));
      applyStimulus(1, 1'($urandom_range(0, 2) != 0), $urandom, $urandom, 3'($urandom_range(0, 7)));
      rsp_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
